pcap_dma_buffer: RTL and testbench
==================================

PCAP_DMA_BUFFER -- requirements
Module: pcap_dma_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: FIFO depth in 32-bit words, a power of two; AW = log2(DEPTH).
REQ-002 SHALL have parameter BURST_LEN, default 256: nominal burst size in words, 1..DEPTH.
REQ-003 SHALL have parameter HEADROOM, default 32: free-word margin at which back-pressure is raised.
REQ-004 SHALL use one clock, clk_i; reset is asynchronous and active-low, reset_n_i.
REQ-005 SHALL have the following ports, one per line (name, direction, width, meaning):
  clk_i  in  1  system clock
  reset_n_i  in  1  async active-low reset
  pcap_dat_i  in  32  capture data word from pcap_core
  pcap_dat_valid_i  in  1  pcap_dat_i valid this cycle
  pcap_done_i  in  1  one-cycle pulse: acquisition finished
  pcap_actv_i  in  1  acquisition active level
  dma_full_o  out  1  back-pressure to pcap_core (dma_full_i)
  dma_req_o  out  1  burst request
  dma_len_o  out  AW+1  words in requested burst
  dma_last_o  out  1  requested burst is final of acquisition
  dma_ack_i  in  1  burst request accepted
  dma_dat_o  out  32  burst data, first-word-fall-through
  dma_dat_valid_o  out  1  dma_dat_o valid
  dma_ready_i  in  1  DMA consumer accepts dma_dat_o
  level_o  out  AW+1  current FIFO occupancy
  overflow_o  out  1  sticky: word dropped
  irq_done_o  out  1  one-cycle pulse: all acquisition data drained

Function
REQ-006 SHALL write pcap_dat_i into FIFO on each cycle with pcap_dat_valid_i=1 and level_o<DEPTH; pointers wrap modulo DEPTH.
REQ-007 SHALL pop a word on each cycle with dma_dat_valid_o=1 and dma_ready_i=1.
REQ-008 Simultaneous write and pop SHALL leave level_o unchanged; level_o SHALL be registered and reflect both 1 cycle later.
REQ-009 dma_full_o SHALL be registered: 1 the cycle after level_o >= DEPTH-HEADROOM, 0 the cycle after level falls below.
REQ-010 Write with level_o=DEPTH SHALL drop the word, leave FIFO unchanged, set overflow_o=1 next cycle.
REQ-011 overflow_o SHALL clear only on a rising edge of pcap_actv_i (re-arm); FIFO contents SHALL NOT be flushed by re-arm.
REQ-012 pcap_done_i SHALL set internal done_pend, held until consumed in DONE; pulses during any state SHALL be latched.
REQ-013 FSM states: IDLE, REQ, XFER, DONE.
REQ-014 IDLE: level_o>=BURST_LEN -> REQ, len=BURST_LEN, last=0; else done_pend and level_o>0 -> REQ, len=level_o, last=(level_o<=BURST_LEN ? 1 : 0 unreachable); else done_pend and level_o=0 -> DONE; else stay.
REQ-015 REQ: dma_req_o=1 with dma_len_o/dma_last_o stable until cycle of dma_ack_i=1; then XFER with remaining=len.
REQ-016 XFER: dma_dat_valid_o=1 while remaining>0; remaining decrements per pop; on final pop -> DONE if last=1, else IDLE.
REQ-017 dma_dat_valid_o and dma_req_o SHALL be 0 outside XFER and REQ respectively; dma_dat_o SHALL hold while valid=1 and ready=0.
REQ-018 DONE: irq_done_o=1 for exactly one cycle, done_pend cleared, -> IDLE.
REQ-019 Writes SHALL continue to be accepted in every state; data order SHALL be preserved end to end.

Reset
REQ-020 reset_n_i=0 SHALL immediately (asynchronously) force state IDLE, pointers 0, level_o=0, done_pend=0, and all outputs 0.
REQ-021 Reset mid-XFER SHALL discard FIFO contents; after release the block SHALL behave as from power-up.

Verification (DEPTH=16, BURST_LEN=4, HEADROOM=2)
REQ-022 Write words 0..7, ready=1, ack 2 cycles after req -> two bursts len=4 last=0, dma_dat_o sequence 0..7, no irq_done_o.
REQ-023 Write 5 words then pcap_done_i -> burst len=4 last=0, then len=1 last=1, irq_done_o single pulse after final pop.
REQ-024 pcap_done_i with FIFO empty -> no dma_req_o, irq_done_o pulse within 2 cycles.
REQ-025 ack held 0, write 17 words -> dma_full_o=1 cycle after level 14, level_o saturates 16, overflow_o=1; pcap_actv_i 0->1 clears overflow_o.
REQ-026 Continuous writes with dma_ready_i toggling 50% -> no loss, no duplication, level_o matches writes minus pops every cycle.
REQ-027 reset_n_i low 3 cycles during XFER -> all outputs 0 same cycle, level_o=0; subsequent 4-word write produces one clean burst.

Source files
------------

// File: rtl/pcap_dma_buffer.sv
// pcap_dma_buffer: capture FIFO between pcap_core and a burst DMA engine.
// Ports:
//   clk_i, reset_n_i            clock, async active-low reset
//   pcap_dat_i/_valid_i         capture words in (dropped when full)
//   pcap_done_i, pcap_actv_i    acquisition done pulse, active level
//   dma_full_o                  registered back-pressure
//   dma_req_o/len_o/last_o      burst request, held until dma_ack_i
//   dma_dat_o/_valid_o          FWFT burst data, popped by dma_ready_i
//   level_o, overflow_o         occupancy, sticky drop flag
//   irq_done_o                  one-cycle pulse once all data drained
module pcap_dma_buffer #(
  parameter int DEPTH     = 1024,
  parameter int BURST_LEN = 256,
  parameter int HEADROOM  = 32,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic [31:0]   pcap_dat_i,
  input  logic          pcap_dat_valid_i,
  input  logic          pcap_done_i,
  input  logic          pcap_actv_i,
  output logic          dma_full_o,
  output logic          dma_req_o,
  output logic [AW:0]   dma_len_o,
  output logic          dma_last_o,
  input  logic          dma_ack_i,
  output logic [31:0]   dma_dat_o,
  output logic          dma_dat_valid_o,
  input  logic          dma_ready_i,
  output logic [AW:0]   level_o,
  output logic          overflow_o,
  output logic          irq_done_o
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] BL_L    = (AW+1)'(BURST_LEN);
  localparam logic [AW:0] FULL_L  = (AW+1)'(DEPTH - HEADROOM);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_DONE
  } state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   remaining;
  logic          done_pend;
  logic          actv_q;
  logic          wr_en;
  logic          pop;
  logic          drop;

  assign drop  = pcap_dat_valid_i && (level_o == DEPTH_L);
  assign wr_en = pcap_dat_valid_i && (level_o != DEPTH_L);
  assign pop   = dma_dat_valid_o && dma_ready_i;

  // Gated so the data bus reads zero whenever no burst word is offered.
  assign dma_dat_o = dma_dat_valid_o ? mem[rd_ptr] : '0;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= pcap_dat_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_o    <= '0;
      dma_full_o <= 1'b0;
      overflow_o <= 1'b0;
      actv_q     <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level_o <= level_o + ONE_L;
        2'b01:   level_o <= level_o - ONE_L;
        default: level_o <= level_o;
      endcase
      dma_full_o <= (level_o >= FULL_L);
      actv_q     <= pcap_actv_i;
      // A drop in the re-arm cycle still counts as lost data.
      if (drop)
        overflow_o <= 1'b1;
      else if (pcap_actv_i && !actv_q)
        overflow_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state           <= S_IDLE;
      dma_req_o       <= 1'b0;
      dma_len_o       <= '0;
      dma_last_o      <= 1'b0;
      dma_dat_valid_o <= 1'b0;
      remaining       <= '0;
      irq_done_o      <= 1'b0;
      done_pend       <= 1'b0;
    end else begin
      irq_done_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (level_o >= BL_L) begin
            dma_req_o  <= 1'b1;
            dma_len_o  <= BL_L;
            dma_last_o <= 1'b0;
            state      <= S_REQ;
          end else if (done_pend && level_o != '0) begin
            dma_req_o  <= 1'b1;
            dma_len_o  <= level_o;
            dma_last_o <= (level_o <= BL_L);
            state      <= S_REQ;
          end else if (done_pend) begin
            irq_done_o <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_REQ: begin
          if (dma_ack_i) begin
            dma_req_o       <= 1'b0;
            remaining       <= dma_len_o;
            dma_dat_valid_o <= 1'b1;
            state           <= S_XFER;
          end
        end
        S_XFER: begin
          if (pop) begin
            remaining <= remaining - ONE_L;
            if (remaining == ONE_L) begin
              dma_dat_valid_o <= 1'b0;
              if (dma_last_o) begin
                irq_done_o <= 1'b1;
                state      <= S_DONE;
              end else begin
                state <= S_IDLE;
              end
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // A pulse landing in DONE must survive into the next acquisition.
      if (pcap_done_i)
        done_pend <= 1'b1;
      else if (state == S_DONE)
        done_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcap_dma_buffer.sv
// tb_pcap_dma_buffer: vector table, directed sequences and a
// queue-based reference model for pcap_dma_buffer.
module tb_pcap_dma_buffer;
  localparam int DEPTH = 16;
  localparam int BL    = 4;
  localparam int HR    = 2;
  localparam int AW    = 4;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [31:0]   pcap_dat_i;
  logic          pcap_dat_valid_i;
  logic          pcap_done_i;
  logic          pcap_actv_i;
  logic          dma_full_o;
  logic          dma_req_o;
  logic [AW:0]   dma_len_o;
  logic          dma_last_o;
  logic          dma_ack_i;
  logic [31:0]   dma_dat_o;
  logic          dma_dat_valid_o;
  logic          dma_ready_i;
  logic [AW:0]   level_o;
  logic          overflow_o;
  logic          irq_done_o;

  always #5 clk_i = ~clk_i;

  pcap_dma_buffer #(
    .DEPTH(DEPTH), .BURST_LEN(BL), .HEADROOM(HR)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .pcap_dat_i(pcap_dat_i),
    .pcap_dat_valid_i(pcap_dat_valid_i),
    .pcap_done_i(pcap_done_i),
    .pcap_actv_i(pcap_actv_i),
    .dma_full_o(dma_full_o),
    .dma_req_o(dma_req_o),
    .dma_len_o(dma_len_o),
    .dma_last_o(dma_last_o),
    .dma_ack_i(dma_ack_i),
    .dma_dat_o(dma_dat_o),
    .dma_dat_valid_o(dma_dat_valid_o),
    .dma_ready_i(dma_ready_i),
    .level_o(level_o),
    .overflow_o(overflow_o),
    .irq_done_o(irq_done_o)
  );

  typedef struct {
    logic        vld;
    logic [31:0] dat;
    logic        actv;
    int          lvl;
    logic        full;
    logic        req;
    logic        ovf;
  } vec_t;

  vec_t        tbl[20];
  logic [31:0] q[$];
  logic [31:0] got[$];
  int          lens[$];
  int          lasts[$];
  bit          m_full, m_ovf, actv_prev, req_prev;
  int          irq_cnt, cyc, pop_cyc, irq_cyc;
  int          tests, fails;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    q.delete(); got.delete(); lens.delete(); lasts.delete();
    m_full = 0; m_ovf = 0; actv_prev = 0; req_prev = 0;
    irq_cnt = 0; pop_cyc = 0; irq_cyc = 0;
  endtask

  task automatic chk_zero();
    chk("z_req", dma_req_o, 0);
    chk("z_len", dma_len_o, 0);
    chk("z_last", dma_last_o, 0);
    chk("z_valid", dma_dat_valid_o, 0);
    chk("z_dat", dma_dat_o, 0);
    chk("z_level", level_o, 0);
    chk("z_full", dma_full_o, 0);
    chk("z_ovf", overflow_o, 0);
    chk("z_irq", irq_done_o, 0);
  endtask

  // Called at the falling edge: compare, record, then advance the model.
  task automatic sample();
    bit wr, pop;
    int sz;
    sz = q.size();
    chk("level", level_o, sz);
    chk("full", dma_full_o, m_full);
    chk("ovf", overflow_o, m_ovf);
    chk("req_valid_excl", dma_req_o & dma_dat_valid_o, 0);
    if (dma_dat_valid_o) begin
      if (sz > 0) chk("dat", dma_dat_o, q[0]);
      else chk("valid_empty", 1, 0);
    end
    if (dma_req_o && !req_prev) begin
      lens.push_back(int'(dma_len_o));
      lasts.push_back(int'(dma_last_o));
    end
    req_prev = dma_req_o;
    pop = dma_dat_valid_o && dma_ready_i;
    wr  = pcap_dat_valid_i && sz < DEPTH;
    if (pop) begin got.push_back(dma_dat_o); pop_cyc = cyc; end
    if (irq_done_o) begin irq_cnt++; irq_cyc = cyc; end
    m_full = (sz >= DEPTH - HR);
    if (pcap_actv_i && !actv_prev) m_ovf = 0;
    if (pcap_dat_valid_i && sz == DEPTH) m_ovf = 1;
    actv_prev = pcap_actv_i;
    if (pop && sz > 0) void'(q.pop_front());
    if (wr) q.push_back(pcap_dat_i);
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk_i);
    sample();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_n_i = 0;
    pcap_dat_i = 0; pcap_dat_valid_i = 0; pcap_done_i = 0;
    pcap_actv_i = 0; dma_ack_i = 0; dma_ready_i = 0;
    @(posedge clk_i); #1;
    chk_zero();
    @(posedge clk_i); #1;
    model_clear();
    reset_n_i = 1;
  endtask

  // wr_mode: 0 every cycle (data = index), 1 random 50%,
  // 2 every cycle unless dma_full_o (random data).
  task automatic run(input int n, input int nwr, input int done_at,
                     input int ack_dly, input bit rnd_rdy,
                     input int wr_mode);
    int w, reqc;
    bit go;
    w = 0; reqc = 0;
    for (int c = 0; c < n; c++) begin
      go = (wr_mode == 0) ||
           (wr_mode == 1 && $urandom_range(0, 1) == 1) ||
           (wr_mode == 2 && !dma_full_o);
      pcap_dat_valid_i = 0;
      if (w < nwr && go) begin
        pcap_dat_valid_i = 1;
        pcap_dat_i = (wr_mode == 0) ? w : $urandom;
        w++;
      end
      pcap_done_i = (c == done_at);
      dma_ready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      reqc = dma_req_o ? reqc + 1 : 0;
      dma_ack_i = dma_req_o && (reqc > ack_dly);
      tick();
    end
    pcap_dat_valid_i = 0; pcap_done_i = 0; dma_ack_i = 0;
    chk("run_all_written", w, nwr);
  endtask

  task automatic seq_check(input string nm, input int n);
    chk({nm, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      chk({nm, "_word"}, got[i], i);
  endtask

  task automatic len_sum_check(input string nm);
    int s;
    s = 0;
    foreach (lens[i]) begin
      s += lens[i];
      chk({nm, "_len_range"},
          (lens[i] >= 1 && lens[i] <= BL), 1);
    end
    chk({nm, "_len_sum"}, s, got.size());
  endtask

  initial begin
    int st, nlast;
    tests = 0; fails = 0; cyc = 0;
    for (int k = 0; k < 20; k++) begin
      tbl[k].vld  = (k <= 16);
      tbl[k].dat  = k;
      tbl[k].actv = (k >= 18);
      tbl[k].lvl  = (k < DEPTH) ? k : DEPTH;
      tbl[k].full = (k >= DEPTH - HR + 1);
      tbl[k].req  = (k >= BL + 1);
      tbl[k].ovf  = (k == 17 || k == 18);
    end

    do_reset();

    // Two full bursts, no done.
    run(40, 8, -1, 2, 0, 0);
    chk("a_bursts", lens.size(), 2);
    if (lens.size() == 2) begin
      chk("a_len0", lens[0], 4); chk("a_last0", lasts[0], 0);
      chk("a_len1", lens[1], 4); chk("a_last1", lasts[1], 0);
    end
    seq_check("a", 8);
    chk("a_irq", irq_cnt, 0);

    // Five words then done: full burst plus final single.
    do_reset();
    run(40, 5, 5, 2, 0, 0);
    chk("b_bursts", lens.size(), 2);
    if (lens.size() == 2) begin
      chk("b_len0", lens[0], 4); chk("b_last0", lasts[0], 0);
      chk("b_len1", lens[1], 1); chk("b_last1", lasts[1], 1);
    end
    seq_check("b", 5);
    chk("b_irq", irq_cnt, 1);
    chk("b_irq_after_pop", irq_cyc > pop_cyc, 1);

    // Done on an empty FIFO.
    do_reset();
    st = cyc;
    run(6, 0, 0, 2, 0, 0);
    chk("c_no_req", lens.size(), 0);
    chk("c_irq", irq_cnt, 1);
    chk("c_irq_lat", (irq_cyc - st) <= 2, 1);

    // Fill past full with no ack, then re-arm.
    do_reset();
    dma_ready_i = 0; dma_ack_i = 0; pcap_done_i = 0;
    for (int k = 0; k < 20; k++) begin
      pcap_dat_valid_i = tbl[k].vld;
      pcap_dat_i       = tbl[k].dat;
      pcap_actv_i      = tbl[k].actv;
      @(negedge clk_i);
      chk("t_level", level_o, tbl[k].lvl);
      chk("t_full", dma_full_o, tbl[k].full);
      chk("t_req", dma_req_o, tbl[k].req);
      chk("t_ovf", overflow_o, tbl[k].ovf);
      sample();
      @(posedge clk_i); #1;
    end
    run(80, 0, -1, 1, 0, 0);
    seq_check("d", 16);
    chk("d_bursts", lens.size(), 4);
    foreach (lens[i]) begin
      chk("d_len", lens[i], 4);
      chk("d_last", lasts[i], 0);
    end
    chk("d_irq", irq_cnt, 0);

    // Back-pressured writes with ready toggling randomly.
    for (int it = 0; it < 2; it++) begin
      do_reset();
      run(1000, 200, -1, $urandom_range(0, 3), 1, 2);
      run(120, 0, 0, $urandom_range(0, 3), 0, 0);
      chk("e_count", got.size(), 200);
      chk("e_irq", irq_cnt, 1);
      chk("e_ovf", overflow_o, 0);
      len_sum_check("e");
      nlast = 0;
      foreach (lasts[i]) nlast += lasts[i];
      chk("e_lasts", nlast <= 1, 1);
    end

    // Reset in the middle of a burst.
    do_reset();
    run(9, 8, -1, 1, 0, 0);
    chk("f_in_xfer", dma_dat_valid_o, 1);
    reset_n_i = 0;
    pcap_dat_valid_i = 0; dma_ready_i = 0;
    #1;
    chk_zero();
    repeat (3) @(posedge clk_i);
    #1;
    model_clear();
    reset_n_i = 1;
    run(30, 4, -1, 1, 0, 0);
    chk("f_bursts", lens.size(), 1);
    if (lens.size() == 1) begin
      chk("f_len", lens[0], 4);
      chk("f_last", lasts[0], 0);
    end
    seq_check("f", 4);
    chk("f_irq", irq_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
